// File: rtl/kernel_cc_srl_fifo_v2.sv
// Parametrised shift-register FIFO with first-word-fall-through read, occupancy count,
// almost-full, synchronous flush and optional sticky error flags (KERNEL_CC_FIFO_ERR_EN).
module kernel_cc_srl_fifo_v2 #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned AFULL_THRESH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_flush,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full,
    output logic                  if_overflow,
    output logic                  if_underflow
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  wr_acc, rd_acc, shift_en;
    logic [ADDR_WIDTH-1:0] rd_idx;

    // Acceptance uses only registered flags: a full FIFO never takes a write.
    always_comb begin
        wr_acc    = if_write & if_write_ce & full_n_q;
        rd_acc    = if_read & if_read_ce & empty_n_q;
        shift_en  = wr_acc & ~if_flush & ~reset;
        count_d   = count_q;
        if (if_flush) begin
            count_d = '0;
        end else if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
        end
    end

    // Storage is deliberately unreset; entry 0 is always the newest word.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_q[i] <= mem_q[i-1];
            end
            mem_q[0] <= if_din;
        end
    end

    assign rd_idx         = ADDR_WIDTH'(count_q - CNT_W'(1));
    assign if_dout        = (count_q != '0) ? mem_q[rd_idx] : mem_q[0];
    assign if_empty_n     = empty_n_q;
    assign if_full_n      = full_n_q;
    assign if_count       = count_q;
    assign if_almost_full = (count_q >= CNT_W'(AFULL_THRESH));

`ifdef KERNEL_CC_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    // Flush wins over a same-cycle violation.
    always_ff @(posedge clk) begin
        if (reset || if_flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q | (if_write & if_write_ce & ~full_n_q);
            underflow_q <= underflow_q | (if_read & if_read_ce & ~empty_n_q);
        end
    end

    assign if_overflow  = overflow_q;
    assign if_underflow = underflow_q;
`else
    assign if_overflow  = 1'b0;
    assign if_underflow = 1'b0;
`endif

endmodule
